cpu_cycle_sequencer: RTL and testbench

//  Timing source for the control unit. Generates the one-hot T-state (i_Cycle_Step)
//  and one-hot M-cycle index (i_Cycle_Count) consumed by every *_Microcode decoder.

---
 rtl/cpu_cycle_sequencer_pkg.sv | 15 +
 rtl/cpu_cycle_sequencer_if.sv | 27 ++
 rtl/cpu_cycle_sequencer_onehot_ring.sv | 17 +
 rtl/cpu_cycle_sequencer.sv | 82 ++++++++
 tb/tb_cpu_cycle_sequencer.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/cpu_cycle_sequencer_pkg.sv
// cpu_timing_pkg: shared T-state/M-cycle constants and sequencer state encoding
package cpu_timing_pkg;
  localparam int STEP_WIDTH_DEF = 4;
  localparam int COUNT_WIDTH_DEF = 8;
  localparam logic [3:0] STEP_T1 = 4'b0001;
  localparam logic [3:0] STEP_T2 = 4'b0010;
  localparam logic [3:0] STEP_T3 = 4'b0100;
  localparam logic [3:0] STEP_T4 = 4'b1000;
  localparam logic [7:0] COUNT_M1 = 8'b0000_0001;
  typedef enum logic [1:0] {
    SEQ_BOOT = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_t;
endpackage

// File: rtl/cpu_cycle_sequencer_if.sv
// cpu_cycle_sequencer_if: control/timing bundle between clock-enable logic, decoders and sequencer
interface cpu_cycle_sequencer_if
  import cpu_timing_pkg::*;
#(
  parameter int STEP_WIDTH = STEP_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
);
  logic clk_enable;
  logic stall;
  logic ir_fetch;
  logic halt_req;
  logic wake;
  logic [STEP_WIDTH-1:0] cycle_step;
  logic [COUNT_WIDTH-1:0] cycle_count;
  logic force_fetch;
  logic ir_latch;
  logic halted;
  logic seq_error;
  modport master (
    output clk_enable, stall, ir_fetch, halt_req, wake,
    input  cycle_step, cycle_count, force_fetch, ir_latch, halted, seq_error
  );
  modport slave (
    input  clk_enable, stall, ir_fetch, halt_req, wake,
    output cycle_step, cycle_count, force_fetch, ir_latch, halted, seq_error
  );
endinterface

// File: rtl/cpu_cycle_sequencer_onehot_ring.sv
// onehot_ring: one-hot rotator with synchronous load and optional saturation at the top bit
module onehot_ring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             hold_at_top,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= WIDTH'(1);
    else if (en) q <= load ? load_value : (hold_at_top && q[WIDTH-1]) ? q : {q[WIDTH-2:0], q[WIDTH-1]};
  end
endmodule

// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: generates one-hot T-state and M-cycle index with boot fetch, stall and HALT
module cpu_cycle_sequencer
  import cpu_timing_pkg::*;
#(
  parameter int STEP_WIDTH = STEP_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input logic i_Clk,
  input logic i_Reset,
  cpu_cycle_sequencer_if.slave bus
);
  seq_state_t state, state_nxt;
  logic [STEP_WIDTH-1:0] step;
  logic [COUNT_WIDTH-1:0] count;
  logic adv, mend, fetch, count_load, err_set, latch_nxt, ir_latch, seq_error;
  always_comb begin
    adv = bus.clk_enable & ~bus.stall;
    mend = adv & step[STEP_WIDTH-1];
    fetch = bus.ir_fetch | (state == SEQ_BOOT);
    state_nxt = state;
    count_load = 1'b0;
    err_set = 1'b0;
    latch_nxt = 1'b0;
    if (mend) begin
      case (state)
        SEQ_BOOT: begin
          state_nxt = SEQ_RUN;
          count_load = 1'b1;
          latch_nxt = 1'b1;
        end
        SEQ_RUN: begin
          latch_nxt = fetch;
          state_nxt = bus.halt_req ? SEQ_HALT : SEQ_RUN;
          count_load = bus.halt_req | fetch;
          err_set = ~bus.halt_req & ~fetch & count[COUNT_WIDTH-1];
        end
        SEQ_HALT: begin
          state_nxt = bus.wake ? SEQ_RUN : SEQ_HALT;
          count_load = 1'b1;
          latch_nxt = bus.wake;
        end
        default: state_nxt = SEQ_BOOT;
      endcase
    end
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= SEQ_BOOT;
      ir_latch <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      state <= state_nxt;
      ir_latch <= latch_nxt;
      seq_error <= seq_error | err_set;
    end
  end
  onehot_ring #(.WIDTH(STEP_WIDTH)) u_step (
    .clk(i_Clk),
    .rst(i_Reset),
    .en(adv),
    .load(1'b0),
    .load_value(STEP_WIDTH'(1)),
    .hold_at_top(1'b0),
    .q(step)
  );
  // count saturates at its top bit; overrun is flagged via err_set instead of wrapping
  onehot_ring #(.WIDTH(COUNT_WIDTH)) u_count (
    .clk(i_Clk),
    .rst(i_Reset),
    .en(mend),
    .load(count_load),
    .load_value(COUNT_WIDTH'(1)),
    .hold_at_top(1'b1),
    .q(count)
  );
  assign bus.cycle_step = step;
  assign bus.cycle_count = count;
  assign bus.force_fetch = (state == SEQ_BOOT);
  assign bus.ir_latch = ir_latch;
  assign bus.halted = (state == SEQ_HALT);
  assign bus.seq_error = seq_error;
endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// tb_cpu_cycle_sequencer: directed checks of boot, fetch, stall, overrun, HALT and reset
module tb_cpu_cycle_sequencer;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  cpu_cycle_sequencer_if sif ();
  cpu_cycle_sequencer dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .bus(sif)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int lat;
    int n;
    logic [3:0] exp_step;
    rst = 1'b1;
    sif.clk_enable = 1'b0;
    sif.stall = 1'b0;
    sif.ir_fetch = 1'b0;
    sif.halt_req = 1'b0;
    sif.wake = 1'b0;
    clk1();
    check("rst_step", sif.cycle_step, 4'b0001);
    check("rst_count", sif.cycle_count, 8'h01);
    check("rst_force", sif.force_fetch, 1'b1);
    check("rst_latch", sif.ir_latch, 1'b0);
    check("rst_halted", sif.halted, 1'b0);
    check("rst_err", sif.seq_error, 1'b0);
    // boot fetch
    rst = 1'b0;
    sif.clk_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("boot_force", sif.force_fetch, 1'b1);
      clk1();
      check("boot_latch", sif.ir_latch, (i == 3) ? 1'b1 : 1'b0);
    end
    check("boot_step", sif.cycle_step, 4'b0001);
    check("boot_count", sif.cycle_count, 8'h01);
    check("boot_force_off", sif.force_fetch, 1'b0);
    sif.clk_enable = 1'b0;
    clk1();
    check("boot_latch_one", sif.ir_latch, 1'b0);
    // clock enable every 4th clk, fetch during second M-cycle
    lat = 0;
    exp_step = 4'b0001;
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < 4; c++) begin
        sif.clk_enable = (c == 0);
        sif.ir_fetch = (sif.cycle_count == 8'h02);
        clk1();
        lat += int'(sif.ir_latch);
      end
      exp_step = {exp_step[2:0], exp_step[3]};
      check("ce_step", sif.cycle_step, exp_step);
      if (t == 3) check("ce_count_m2", sif.cycle_count, 8'h02);
    end
    check("ce_count_m1", sif.cycle_count, 8'h01);
    check("ce_latches", lat, 1);
    sif.clk_enable = 1'b0;
    sif.ir_fetch = 1'b0;
    // stall at T2 for 5 clks
    sif.clk_enable = 1'b1;
    clk1();
    check("stall_t2", sif.cycle_step, 4'b0010);
    sif.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clk1();
      check("stall_step", sif.cycle_step, 4'b0010);
      check("stall_latch", sif.ir_latch, 1'b0);
    end
    check("stall_count", sif.cycle_count, 8'h01);
    sif.stall = 1'b0;
    n = 6;
    while (sif.cycle_count == 8'h01 && n < 20) begin
      clk1();
      n++;
    end
    check("stall_delay", n, 9);
    check("stall_after_count", sif.cycle_count, 8'h02);
    // overrun with no fetch
    repeat (24) clk1();
    check("ovr_count_top", sif.cycle_count, 8'h80);
    check("ovr_err_pre", sif.seq_error, 1'b0);
    repeat (12) clk1();
    check("ovr_count_hold", sif.cycle_count, 8'h80);
    check("ovr_err", sif.seq_error, 1'b1);
    check("ovr_step", sif.cycle_step, 4'b0001);
    // HALT entry at T4, wake at T2
    repeat (3) clk1();
    check("halt_t4", sif.cycle_step, 4'b1000);
    sif.halt_req = 1'b1;
    clk1();
    sif.halt_req = 1'b0;
    check("halt_on", sif.halted, 1'b1);
    check("halt_count", sif.cycle_count, 8'h01);
    check("halt_step", sif.cycle_step, 4'b0001);
    check("halt_latch", sif.ir_latch, 1'b0);
    clk1();
    check("halt_rot", sif.cycle_step, 4'b0010);
    sif.wake = 1'b1;
    clk1();
    clk1();
    check("wake_pending", sif.halted, 1'b1);
    check("wake_pending_latch", sif.ir_latch, 1'b0);
    clk1();
    check("wake_halted", sif.halted, 1'b0);
    check("wake_latch", sif.ir_latch, 1'b1);
    check("wake_count", sif.cycle_count, 8'h01);
    check("wake_step", sif.cycle_step, 4'b0001);
    sif.wake = 1'b0;
    clk1();
    check("wake_latch_one", sif.ir_latch, 1'b0);
    // reset at T3 of count 04
    repeat (9) clk1();
    check("pre_rst_count", sif.cycle_count, 8'h04);
    check("pre_rst_step", sif.cycle_step, 4'b0100);
    check("pre_rst_err", sif.seq_error, 1'b1);
    rst = 1'b1;
    sif.ir_fetch = 1'b1;
    clk1();
    check("mid_rst_step", sif.cycle_step, 4'b0001);
    check("mid_rst_count", sif.cycle_count, 8'h01);
    check("mid_rst_err", sif.seq_error, 1'b0);
    check("mid_rst_latch", sif.ir_latch, 1'b0);
    check("mid_rst_force", sif.force_fetch, 1'b1);
    rst = 1'b0;
    sif.ir_fetch = 1'b0;
    sif.clk_enable = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
